error_decoder: RTL
==================

ERROR_DECODER -- requirements
Module: error_decoder

Interface
REQ-001 Parameter ERROR_LENGTH, default 3, frame length in clocks (legal 3..7); level-1 frame = ERROR, level-2 frame = STOP.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 err_in  input  1  serial pulse-width-coded error line from the remote error coder; idle low.
REQ-005 live_rising  input  1  one-cycle spill-start strobe; clears per-spill status.
REQ-006 error_pulse  output  1  one-cycle strobe per decoded ERROR frame.
REQ-007 stop_pulse  output  1  one-cycle strobe per decoded STOP frame.
REQ-008 stop_active  output  1  STOP level; toggles on each STOP frame (rise/fall pairs).
REQ-009 error_seen  output  1  sticky: an ERROR frame was decoded this spill.
REQ-010 frame_err  output  1  one-cycle strobe on malformed frame (stuck high or early restart).
REQ-011 err_cnt  output  8  ERROR frames this spill, saturating at 255.
REQ-012 stop_cnt  output  8  STOP frames this spill, saturating at 255.

Function
REQ-013 Sampled line s = err_in, or the synchronizer output per REQ-031; FSM states IDLE, HIGH, TAIL, STUCK; 3-bit run counter.
REQ-014 IDLE: s=1 -> HIGH, run=1; s=0 -> stay.
REQ-015 HIGH: s=1 -> run+1; run reaching ERROR_LENGTH -> frame_err pulse, go STUCK.
REQ-016 HIGH, s=0: run=1 -> error_pulse; run=2 -> stop_pulse; run>=3 -> frame_err; then TAIL with tail count = run+1.
REQ-017 Decode strobes are registered, asserted the cycle after the edge that samples the first low (1-clock decode latency from line fall).
REQ-018 TAIL: s=0 increments tail count; when count reaches ERROR_LENGTH -> IDLE (ERROR_LENGTH=3: ERROR has 2 low cycles, STOP 1).
REQ-019 TAIL, s=1 before frame end: frame_err pulse, enter HIGH with run=1 (the high is treated as a new frame start).
REQ-020 Back-to-back frames (new high on the first cycle after frame end) are decoded normally, no frame_err.
REQ-021 STUCK: remain until s=0, then IDLE; no ERROR/STOP decode from a stuck frame.
REQ-022 error_pulse: error_seen <= 1, err_cnt +1 unless 255; stop_pulse: stop_active inverts, stop_cnt +1 unless 255.
REQ-023 live_rising clears error_seen, stop_active, err_cnt, stop_cnt; FSM unaffected (a frame in flight still decodes).
REQ-024 live_rising with a decode event in the same cycle: clear first, then apply event (count=1, error_seen=1 or stop_active=1).
REQ-025 At most one of error_pulse, stop_pulse, frame_err is high in any cycle.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, run/tail counters 0, synchronizer flops 0.
REQ-027 All outputs reset to 0: error_pulse, stop_pulse, stop_active, error_seen, frame_err, err_cnt, stop_cnt.
REQ-028 Reset mid-frame aborts the frame with no strobe; after release, decoding resumes only from IDLE on the next s=1.
REQ-029 A line held high at reset release is decoded as a new frame starting at the first sampled high.

Configuration
REQ-030 Macro ERROR_DECODER_SYNC_EN selects the err_in input path.
REQ-031 Defined: err_in passes through a 2-flop synchronizer before the FSM; all decode latencies grow by 2 clocks.
REQ-032 Undefined: err_in feeds the FSM directly (same-clock-domain source); latency per REQ-017.

Verification
REQ-033 Macro undefined, err_in 1,0,0 from cycle 10 -> error_pulse high cycle 12 only, err_cnt=1, error_seen=1, no frame_err.
REQ-034 err_in 1,1,0 twice back-to-back -> two stop_pulses 3 clocks apart, stop_active 0->1->0, stop_cnt=2.
REQ-035 err_in high 5 cycles -> one frame_err once run reaches 3, no error/stop pulse, FSM to IDLE after line falls.
REQ-036 err_in 1,0,1,0,0 -> error_pulse, then frame_err at second high, then error_pulse; err_cnt=2.
REQ-037 err_cnt=255 plus one ERROR frame -> stays 255; then live_rising with same-cycle stop_pulse -> err_cnt=0, stop_cnt=1, stop_active=1.
REQ-038 rst_n low mid-STOP frame (after first high) -> all outputs 0, no stop_pulse; ERROR_DECODER_SYNC_EN defined repeats REQ-033 with pulse at cycle 14.

Source files
------------

// File: rtl/error_decoder.sv
// rtl/error_decoder.sv - pulse-width ERROR/STOP frame decoder with per-spill status
// Optional 2-flop err_in synchronizer enabled by defining ERROR_DECODER_SYNC_EN.
module error_decoder #(
    parameter int ERROR_LENGTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       err_in,
    input  logic       live_rising,
    output logic       error_pulse,
    output logic       stop_pulse,
    output logic       stop_active,
    output logic       error_seen,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic [7:0] stop_cnt
);

    localparam logic [2:0] LEN = 3'(ERROR_LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        TAIL  = 2'd2,
        STUCK = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] run;
    logic [2:0] run_nx;
    logic [2:0] tail;
    logic [2:0] tail_nx;
    logic [2:0] run_inc;
    logic [2:0] tail_inc;
    logic       line;
    logic       err_ev;
    logic       stop_ev;
    logic       ferr_ev;

`ifdef ERROR_DECODER_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= err_in;
            sync_q2 <= sync_q1;
        end
    end

    assign line = sync_q2;
`else
    assign line = err_in;
`endif

    // run never exceeds LEN-1 while in HIGH, and tail never exceeds LEN-1 in TAIL,
    // so a 3-bit increment cannot wrap for any legal ERROR_LENGTH.
    assign run_inc  = run + 3'd1;
    assign tail_inc = tail + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= 3'd0;
            tail  <= 3'd0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
            tail  <= tail_nx;
        end
    end

    always_comb begin
        state_nx = state;
        run_nx   = run;
        tail_nx  = tail;
        err_ev   = 1'b0;
        stop_ev  = 1'b0;
        ferr_ev  = 1'b0;
        case (state)
            IDLE: begin
                if (line) begin
                    state_nx = HIGH;
                    run_nx   = 3'd1;
                end
            end
            HIGH: begin
                if (line) begin
                    run_nx = run_inc;
                    if (run_inc >= LEN) begin
                        ferr_ev  = 1'b1;
                        state_nx = STUCK;
                    end
                end else begin
                    if (run == 3'd1) begin
                        err_ev = 1'b1;
                    end else if (run == 3'd2) begin
                        stop_ev = 1'b1;
                    end else begin
                        ferr_ev = 1'b1;
                    end
                    // The first low already counts toward the frame length.
                    if (run_inc >= LEN) begin
                        state_nx = IDLE;
                        run_nx   = 3'd0;
                        tail_nx  = 3'd0;
                    end else begin
                        state_nx = TAIL;
                        tail_nx  = run_inc;
                    end
                end
            end
            TAIL: begin
                if (line) begin
                    ferr_ev  = 1'b1;
                    state_nx = HIGH;
                    run_nx   = 3'd1;
                    tail_nx  = 3'd0;
                end else if (tail_inc >= LEN) begin
                    state_nx = IDLE;
                    run_nx   = 3'd0;
                    tail_nx  = 3'd0;
                end else begin
                    tail_nx = tail_inc;
                end
            end
            STUCK: begin
                if (!line) begin
                    state_nx = IDLE;
                    run_nx   = 3'd0;
                    tail_nx  = 3'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                run_nx   = 3'd0;
                tail_nx  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            error_pulse <= err_ev;
            stop_pulse  <= stop_ev;
            frame_err   <= ferr_ev;
        end
    end

    // Spill clear takes effect first so a coincident strobe lands on cleared status.
    logic [7:0] err_base;
    logic [7:0] stop_base;
    logic       seen_base;
    logic       active_base;

    assign err_base    = live_rising ? 8'd0 : err_cnt;
    assign stop_base   = live_rising ? 8'd0 : stop_cnt;
    assign seen_base   = live_rising ? 1'b0 : error_seen;
    assign active_base = live_rising ? 1'b0 : stop_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt     <= 8'd0;
            stop_cnt    <= 8'd0;
            error_seen  <= 1'b0;
            stop_active <= 1'b0;
        end else begin
            err_cnt     <= (error_pulse && (err_base != 8'hFF)) ? err_base + 8'd1 : err_base;
            stop_cnt    <= (stop_pulse && (stop_base != 8'hFF)) ? stop_base + 8'd1 : stop_base;
            error_seen  <= seen_base | error_pulse;
            stop_active <= active_base ^ stop_pulse;
        end
    end

endmodule
